// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns one load or store into a single outstanding
// data-memory request, stalls the pipeline while it is in flight, and formats load data.
module mem_lsu #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_valid_i,
  input  logic             MEM_mem_read_i,
  input  logic             MEM_mem_write_i,
  input  logic [2:0]       MEM_funct3_i,
  input  logic [width-1:0] MEM_alu_out_i,
  input  logic [width-1:0] MEM_rs2_out_i,
  input  logic             dmem_resp,
  input  logic [width-1:0] dmem_rdata,
  output logic [width-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [width-1:0] dmem_wdata,
  output logic [3:0]       dmem_mbe,
  output logic             MEM_stall_o,
  output logic [width-1:0] MEM_load_data_o,
  output logic             MEM_misaligned_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic             access, is_store, legal, misaligned, start;
  logic [1:0]       off, size;
  logic [3:0]       mbe_c;
  logic [width-1:0] wdata_c;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;
  logic [width-1:0] shifted, load_fmt;

  // Access classification; a simultaneous read and write counts as a store.
  always_comb begin
    access   = MEM_valid_i & (MEM_mem_read_i | MEM_mem_write_i);
    is_store = MEM_mem_write_i;
    off      = MEM_alu_out_i[1:0];
    size     = MEM_funct3_i[1:0];
    if (is_store)
      legal = (MEM_funct3_i <= 3'd2);
    else
      legal = (MEM_funct3_i != 3'd3) && (MEM_funct3_i != 3'd6) && (MEM_funct3_i != 3'd7);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      default: misaligned = (off != 2'd0);
    endcase
    case (size)
      2'd0: begin
        mbe_c   = 4'b0001 << off;
        wdata_c = {4{MEM_rs2_out_i[7:0]}};
      end
      2'd1: begin
        mbe_c   = 4'b0011 << off;
        wdata_c = {2{MEM_rs2_out_i[15:0]}};
      end
      default: begin
        mbe_c   = 4'b1111;
        wdata_c = MEM_rs2_out_i;
      end
    endcase
    start            = ~rst & (state == IDLE) & access & legal & ~misaligned;
    MEM_misaligned_o = ~rst & (state == IDLE) & access & legal & misaligned;
  end

  always_comb begin
    state_next  = state;
    MEM_stall_o = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = BUSY;
          MEM_stall_o = 1'b1;
        end
      end
      BUSY: begin
        MEM_stall_o = ~rst;
        if (dmem_resp) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Load data is formatted with the funct3/offset captured at issue time.
  always_comb begin
    shifted = dmem_rdata >> {lat_off, 3'b000};
    case (lat_f3)
      3'd0:    load_fmt = {{(width-8){shifted[7]}}, shifted[7:0]};
      3'd1:    load_fmt = {{(width-16){shifted[15]}}, shifted[15:0]};
      3'd4:    load_fmt = {{(width-8){1'b0}}, shifted[7:0]};
      3'd5:    load_fmt = {{(width-16){1'b0}}, shifted[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_address    <= '0;
      dmem_read       <= 1'b0;
      dmem_write      <= 1'b0;
      dmem_wdata      <= '0;
      dmem_mbe        <= 4'b0000;
      MEM_load_data_o <= '0;
      lat_f3          <= 3'd0;
      lat_off         <= 2'd0;
    end else begin
      if (start) begin
        dmem_address <= {MEM_alu_out_i[width-1:2], 2'b00};
        dmem_read    <= ~is_store;
        dmem_write   <= is_store;
        dmem_wdata   <= wdata_c;
        dmem_mbe     <= mbe_c;
        lat_f3       <= MEM_funct3_i;
        lat_off      <= off;
      end
      if (state == BUSY && dmem_resp) begin
        dmem_read  <= 1'b0;
        dmem_write <= 1'b0;
        if (dmem_read) MEM_load_data_o <= load_fmt;
      end
    end
  end

endmodule
